// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core: fetch FSM encoding and core constants.
package npc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_t;

    // Canonical no-op (addi x0, x0, 0) presented when no real instruction is held.
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // A fetch target is legal only when word-aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem read, holds the fetched word
// stable for the core until commit, redirects on flush.
module ifu
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic [31:0] commit_npc,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    ifu_state_t  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_fault_q, inst_fault_d;

    // Redirect request collected from every state, applied once below.
    logic        go;
    logic [31:0] go_pc;

    // Next-state logic: per-state events, then a common redirect step.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        redir_pc_d   = redir_pc_q;
        drop_d       = drop_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        go           = 1'b0;
        go_pc        = fetch_pc_q;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    go    = 1'b1;
                    go_pc = flush_pc;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A request already on the bus cannot be withdrawn: mark its
                // response as orphaned and remember where to go afterwards.
                if (flush) begin
                    drop_d     = 1'b1;
                    redir_pc_d = flush_pc;
                end
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    if (imem_resp_valid) begin
                        drop_d = 1'b0;
                        go     = 1'b1;
                        go_pc  = flush_pc;
                    end else begin
                        drop_d     = 1'b1;
                        redir_pc_d = flush_pc;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                        go     = 1'b1;
                        go_pc  = redir_pc_q;
                    end else begin
                        inst_d       = imem_resp_err ? NOP_INST : imem_resp_data;
                        inst_pc_d    = fetch_pc_q;
                        inst_fault_d = imem_resp_err;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    go    = 1'b1;
                    go_pc = flush_pc;
                end else if (inst_ready) begin
                    go    = 1'b1;
                    go_pc = commit_npc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Aligned targets start a new fetch; misaligned ones never reach the
        // bus and are presented directly as a faulting NOP.
        if (go) begin
            fetch_pc_d = go_pc;
            inst_d     = NOP_INST;
            if (pc_misaligned(go_pc)) begin
                state_d      = S_HOLD;
                inst_pc_d    = go_pc;
                inst_fault_d = 1'b1;
            end else begin
                state_d      = S_REQ;
                inst_fault_d = 1'b0;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            drop_q       <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            redir_pc_q   <= redir_pc_d;
            drop_q       <= drop_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    // Outputs come only from registers and the state decode.
    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_req_addr  = fetch_pc_q;
        inst_valid     = (state_q == S_HOLD);
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        inst_fault     = inst_fault_q;
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a per-cycle vector table plus hand-written
// stall and mid-transaction reset sequences.
module tb_ifu;

    localparam logic [31:0] R = 32'h8000_0000;
    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] commit_npc;
    logic        flush;
    logic [31:0] flush_pc;

    int checks = 0;
    int errors = 0;

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault),
        .commit_npc      (commit_npc),
        .flush           (flush),
        .flush_pc        (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        rerr;
        logic        irdy;
        logic [31:0] npc;
        logic        fl;
        logic [31:0] fpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_flt;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(
        input logic rdy, input logic rv, input logic [31:0] rdata, input logic rerr,
        input logic irdy, input logic [31:0] npc, input logic fl, input logic [31:0] fpc,
        input logic e_req, input logic [31:0] e_addr, input logic e_iv,
        input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_flt);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.rerr = rerr;
        v.irdy = irdy; v.npc = npc; v.fl = fl; v.fpc = fpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_flt = e_flt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_iv, input logic [31:0] e_inst,
                            input logic [31:0] e_pc, input logic e_flt);
        chk({tag, ".req_valid"},  {31'b0, imem_req_valid}, {31'b0, e_req});
        chk({tag, ".req_addr"},   imem_req_addr, e_addr);
        chk({tag, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, e_iv});
        chk({tag, ".inst"},       inst, e_inst);
        chk({tag, ".inst_pc"},    inst_pc, e_pc);
        chk({tag, ".inst_fault"}, {31'b0, inst_fault}, {31'b0, e_flt});
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        inst_ready      = 1'b0;
        commit_npc      = '0;
        flush           = 1'b0;
        flush_pc        = '0;
    endtask

    // Leaves the bench at a falling edge in the first cycle after release.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int acc;

        // cycle 1 = first cycle after reset release (S_IDLE)
        vecs[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, R,             0, N,             R,             0);
        vecs[1]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, R,             0, N,             R,             0);
        vecs[2]  = mk(0, 1, 32'h0050_0093, 0, 0, 32'h0,         0, 32'h0,         0, R,             0, N,             R,             0);
        vecs[3]  = mk(0, 0, 32'h0,         0, 1, 32'h8000_0004, 0, 32'h0,         0, R,             1, 32'h0050_0093, R,             0);
        vecs[4]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0004, 0, N,             R,             0);
        vecs[5]  = mk(0, 1, 32'h00a0_0113, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_0004, 0, N,             R,             0);
        // commit to a misaligned npc
        vecs[6]  = mk(0, 0, 32'h0,         0, 1, 32'h8000_0102, 0, 32'h0,         0, 32'h8000_0004, 1, 32'h00a0_0113, 32'h8000_0004, 0);
        vecs[7]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_0102, 1, N,             32'h8000_0102, 1);
        // flush beats same-cycle commit
        vecs[8]  = mk(0, 0, 32'h0,         0, 1, 32'h8000_0200, 1, 32'h8000_0800, 0, 32'h8000_0102, 1, N,             32'h8000_0102, 1);
        vecs[9]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0800, 0, N,             32'h8000_0102, 0);
        // flush in S_WAIT, response three cycles later is discarded
        vecs[10] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_1000, 0, 32'h8000_0800, 0, N,             32'h8000_0102, 0);
        vecs[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_0800, 0, N,             32'h8000_0102, 0);
        vecs[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_0800, 0, N,             32'h8000_0102, 0);
        vecs[13] = mk(0, 1, 32'hdead_beef, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_0800, 0, N,             32'h8000_0102, 0);
        vecs[14] = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_1000, 0, N,             32'h8000_0102, 0);
        // bus error
        vecs[15] = mk(0, 1, 32'hffff_ffff, 1, 0, 32'h0,         0, 32'h0,         0, 32'h8000_1000, 0, N,             32'h8000_0102, 0);
        vecs[16] = mk(0, 0, 32'h0,         0, 1, 32'h8000_1004, 0, 32'h0,         0, 32'h8000_1000, 1, N,             32'h8000_1000, 1);
        // flush with same-cycle accept in S_REQ
        vecs[17] = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_3000, 1, 32'h8000_1004, 0, N,             32'h8000_1000, 0);
        vecs[18] = mk(0, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_1004, 0, N,             32'h8000_1000, 0);
        // flush in S_REQ without accept, then a second flush to a misaligned target
        vecs[19] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_4000, 1, 32'h8000_3000, 0, N,             32'h8000_1000, 0);
        vecs[20] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_5002, 1, 32'h8000_3000, 0, N,             32'h8000_1000, 0);
        vecs[21] = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_3000, 0, N,             32'h8000_1000, 0);
        vecs[22] = mk(0, 1, 32'h4444_4444, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_3000, 0, N,             32'h8000_1000, 0);
        vecs[23] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_6000, 0, 32'h8000_5002, 1, N,             32'h8000_5002, 1);
        // flush in the same cycle as the response
        vecs[24] = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_6000, 0, N,             32'h8000_5002, 0);
        vecs[25] = mk(0, 1, 32'h2222_2222, 0, 0, 32'h0,         1, 32'h8000_7000, 0, 32'h8000_6000, 0, N,             32'h8000_5002, 0);
        vecs[26] = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_7000, 0, N,             32'h8000_5002, 0);
        vecs[27] = mk(0, 1, 32'h3333_3333, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_7000, 0, N,             32'h8000_5002, 0);
        vecs[28] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h8000_7000, 1, 32'h3333_3333, 32'h8000_7000, 0);
        vecs[29] = mk(0, 0, 32'h0,         0, 1, 32'h8000_0000, 1, 32'h8000_8000, 0, 32'h8000_7000, 1, 32'h3333_3333, 32'h8000_7000, 0);
        vecs[30] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_8000, 0, N,             32'h8000_7000, 0);

        // Reset values while reset is held
        idle_inputs();
        rst = 1'b0;
        #12;
        chk_outs("reset", 0, R, 0, N, R, 0);

        do_reset();
        for (int i = 0; i < 31; i++) begin
            imem_req_ready  = vecs[i].rdy;
            imem_resp_valid = vecs[i].rv;
            imem_resp_data  = vecs[i].rdata;
            imem_resp_err   = vecs[i].rerr;
            inst_ready      = vecs[i].irdy;
            commit_npc      = vecs[i].npc;
            flush           = vecs[i].fl;
            flush_pc        = vecs[i].fpc;
            #1;
            chk_outs($sformatf("vec%0d", i + 1), vecs[i].e_req, vecs[i].e_addr,
                     vecs[i].e_iv, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_flt);
            @(negedge clk);
        end

        // Stalled request: address stable, exactly one accept
        do_reset();
        chk("stall.idle_req", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d.req_valid", k), {31'b0, imem_req_valid}, 32'd1);
            chk($sformatf("stall%0d.req_addr", k), imem_req_addr, R);
            if (imem_req_valid && imem_req_ready) acc++;
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        chk("stall.final_addr", imem_req_addr, R);
        if (imem_req_valid && imem_req_ready) acc++;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("stall.wait_req", {31'b0, imem_req_valid}, 32'd0);
        // Flush while waiting so an orphan mark is pending when reset hits
        flush    = 1'b1;
        flush_pc = 32'h8000_9000;
        if (imem_req_valid && imem_req_ready) acc++;
        @(negedge clk);
        flush = 1'b0;
        if (imem_req_valid && imem_req_ready) acc++;
        chk("stall.accepts", acc, 32'd1);

        // Asynchronous reset in S_WAIT
        #2 rst = 1'b0;
        #1;
        chk_outs("rst_wait", 0, R, 0, N, R, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_wait.c1_req", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        imem_req_ready = 1'b1;
        chk("rst_wait.c2_req", {31'b0, imem_req_valid}, 32'd1);
        chk("rst_wait.c2_addr", imem_req_addr, R);
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0093;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        chk_outs("rst_wait.c4", 0, R, 1, 32'h0050_0093, R, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the NPC core. Sits directly upstream of the single-cycle core datapath: it issues read requests to the instruction memory port, captures the returned word, and holds it stable on `inst` for the whole cycle in which the core executes it. Fetch is strictly sequential per commit: the next address is the `commit_npc` the core supplies on the commit handshake, or `flush_pc` on a redirect. At most one memory request is outstanding.

## Interface
- `RESET_PC`, 32'h8000_0000, first fetch address after reset.
- `NOP_INST`, 32'h0000_0013, value driven on `inst` whenever no valid word is held.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_resp_valid`  in  1  response word valid; the memory always accepts responses.
- `imem_resp_data`  in  32  fetched instruction.
- `imem_resp_err`  in  1  bus error on this response.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a fetched instruction.
- `inst_ready`  in  1  core commits the held instruction this cycle.
- `inst`  out  32  instruction to the core.
- `inst_pc`  out  32  address of `inst`.
- `inst_fault`  out  1  fetch fault: misaligned address or bus error; `inst` = NOP_INST.
- `commit_npc`  in  32  next PC, sampled only when `inst_valid && inst_ready`.
- `flush`  in  1  redirect request (trap/mret); has priority over every other event.
- `flush_pc`  in  32  redirect target, sampled when `flush` = 1.

## Operation
- Registers: `state`, `fetch_pc`, `drop`, `inst`, `inst_pc`, `inst_fault`.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD.
- S_IDLE: entered only from reset; one cycle later goes to S_REQ.
- S_REQ: `imem_req_valid` = 1 and `imem_req_addr` = `fetch_pc`. Address stays stable until accepted. On `imem_req_ready` go to S_WAIT.
- S_WAIT: on `imem_resp_valid` with `drop` = 0, capture the response into `inst`, set `inst_pc` = `fetch_pc` and `inst_fault` = `imem_resp_err`, then go to S_HOLD. If `drop` = 1, discard the word, clear `drop` and return to S_REQ.
- S_HOLD: `inst_valid` = 1. On `inst_ready`, set `fetch_pc` = `commit_npc`. If `commit_npc[1:0]` = 0, go to S_REQ. Otherwise stay in S_HOLD presenting `inst` = NOP_INST, `inst_pc` = `commit_npc`, `inst_fault` = 1; no memory request is issued.
- Flush in S_IDLE or S_HOLD: `fetch_pc` = `flush_pc`, go to S_REQ, and `inst_valid` drops the next cycle. Flush wins over a same-cycle `inst_ready`.
- Flush in S_REQ: the pending request is not withdrawn. Set `drop` = 1 and `fetch_pc` is reloaded with `flush_pc` only after the orphan response is discarded, so `flush_pc` is latched into a redirect register. A same-cycle accept is treated identically.
- Flush in S_WAIT, including the cycle `imem_resp_valid` = 1: the response is discarded. If the response arrives in the same cycle, go to S_REQ at `flush_pc`; otherwise set `drop`.
- A second flush while `drop` = 1 overwrites the redirect target; `drop` stays 1.
- Misaligned `flush_pc` is handled like a misaligned `commit_npc`: fault presented in S_HOLD once any orphan response has drained.

## Timing
- Reset values: `state` = S_IDLE, `fetch_pc` = RESET_PC, `imem_req_valid` = 0, `inst_valid` = 0, `inst` = NOP_INST, `inst_pc` = RESET_PC, `inst_fault` = 0, `drop` = 0.
- Reset asserted mid-transaction forces the reset values immediately. The memory side must tolerate the abandoned request.
- All outputs are registered or decoded from `state` only; there is no combinational path from any input to any output.
- Zero-wait memory (ready and response in the cycle after accept): request accepted in cycle N, response in N+1, `inst_valid` in N+2, commit at earliest N+2, next request N+3. Steady-state throughput is 1 instruction per 3 cycles.
- The first `imem_req_valid` appears in cycle 2 after reset deassertion.

## Structure
- Shared package `npc_pkg` holds: the `ifu_state_t` enum (S_IDLE, S_REQ, S_WAIT, S_HOLD), `NOP_INST`, and `RESET_PC_DEFAULT`; `control` reuses NOP_INST.
- No sub-module. Single flat FSM plus registers, about 150–200 lines.

## Test plan
- Reset, `imem_req_ready` = 1, response 0x00500093 one cycle after accept -> `imem_req_addr` = 0x80000000 in cycle 2; `inst_valid` in cycle 4 with `inst` = 0x00500093 and `inst_pc` = 0x80000000.
- `imem_req_ready` low for 5 cycles -> `imem_req_valid` and `imem_req_addr` stay constant; exactly one accept is counted.
- Commit with `commit_npc` = 0x80000102 -> no request; `inst_fault` = 1, `inst` = 0x00000013, `inst_pc` = 0x80000102.
- Flush to 0x80001000 in S_WAIT, response arrives 3 cycles later -> response discarded, next request to 0x80001000, no spurious `inst_valid`.
- Flush and `inst_ready` in the same S_HOLD cycle -> next request to `flush_pc`; `commit_npc` is ignored.
- `imem_resp_err` = 1 -> `inst_fault` = 1 and `inst` = 0x00000013; `rst` asserted during S_WAIT -> all reset values and the next request at 0x80000000.
